// File: rtl/turn_pkg.sv
// -----------------------------------------------------------------------------
// turn_pkg
//   Shared types and default timing constants for the turn-signal input
//   conditioner.
//
//   db_state_t           : per-channel debounce FSM state encoding
//   DEF_DEBOUNCE_CYCLES  : default debounce window (10 ms at 50 MHz)
//   DEF_STEP_DIV         : default step-tick period (0.25 s at 50 MHz)
// -----------------------------------------------------------------------------
package turn_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_STEP_DIV        = 12500000;

endpackage

// File: rtl/turn_debounce_ch.sv
// -----------------------------------------------------------------------------
// turn_debounce_ch
//   One input channel: a 2-flop synchroniser followed by a 4-state debounce
//   FSM. A new level is accepted only after it has been seen on the
//   synchronised signal for DEBOUNCE_CYCLES consecutive cycles; any earlier
//   reversal sends the FSM back to its settled state and discards progress.
//
// Ports
//   clk       in   system clock, posedge
//   rst_n     in   asynchronous active-low reset
//   raw_i     in   raw switch level, asynchronous to clk
//   stable_o  out  debounced level (registered)
// -----------------------------------------------------------------------------
module turn_debounce_ch
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            meta_q;
  logic            sync_q;
  db_state_t       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  // Two-flop synchroniser; meta_q may go metastable and is never used directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // The count only advances in the transitional states and is cleared on
  // every exit from them, so it never exceeds DB_LAST and cannot wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    unique case (state_q)
      S_LOW: begin
        if (sync_q) begin
          state_d = S_RISE;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!sync_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = S_HIGH;
          stable_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d   = cnt_q + DB_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          state_d = S_FALL;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (sync_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = S_LOW;
          stable_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d   = cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = S_LOW;
        cnt_d    = '0;
        stable_d = 1'b0;
      end
    endcase
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// -----------------------------------------------------------------------------
// turn_input_conditioner
//   Front end for the turn-signal sequencer. Raw left/right switches are
//   synchronised and debounced per channel, arbitrated into mutually
//   exclusive registered requests, and a prescaler produces a blink-step
//   pulse while any request is active.
//
//   Optional feature macro: TURN_HAZARD_EN
//     defined   : both channels high -> hazard=1 (conflict=0), prescaler runs
//     undefined : both channels high -> conflict=1, hazard tied 0
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   left_raw   in   raw left switch (asynchronous, may bounce)
//   right_raw  in   raw right switch (asynchronous, may bounce)
//   left       out  clean left request (left alone stable-high)
//   right      out  clean right request (right alone stable-high)
//   conflict   out  both channels stable-high (error)
//   hazard     out  both channels stable-high, hazard mode
//   step_tick  out  one-cycle pulse every STEP_DIV cycles while a request is on
// -----------------------------------------------------------------------------
module turn_input_conditioner
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STEP_DIV        = DEF_STEP_DIV,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES),
  parameter int STEP_W          = $clog2(STEP_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic left_raw,
  input  logic right_raw,
  output logic left,
  output logic right,
  output logic conflict,
  output logic hazard,
  output logic step_tick
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  logic ls, rs;

  turn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (left_raw),
    .stable_o (ls)
  );

  turn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_i    (right_raw),
    .stable_o (rs)
  );

  // ---- arbitration stage ----------------------------------------------------
  logic left_q, left_d;
  logic right_q, right_d;
  logic conflict_q, conflict_d;
  logic hazard_q, hazard_d;

  always_comb begin
    left_d     = ls & ~rs;
    right_d    = rs & ~ls;
`ifdef TURN_HAZARD_EN
    conflict_d = 1'b0;
    hazard_d   = ls & rs;
`else
    conflict_d = ls & rs;
    hazard_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      conflict_q <= 1'b0;
      hazard_q   <= 1'b0;
    end else begin
      left_q     <= left_d;
      right_q    <= right_d;
      conflict_q <= conflict_d;
      hazard_q   <= hazard_d;
    end
  end

  // ---- step prescaler stage -------------------------------------------------
  // The count starts on the first edge that sees an active request, so the
  // first tick lands STEP_DIV edges after the request output rises. Dropping
  // to idle clears the count, so a new request always starts a full period.
  logic              run;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              tick_q, tick_d;

  assign run = left_q | right_q | hazard_q;

  always_comb begin
    step_cnt_d = '0;
    tick_d     = 1'b0;
    if (run) begin
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + STEP_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign conflict  = conflict_q;
  assign hazard    = hazard_q;
  // A tick registered on the same edge the request dropped must not leak out.
  assign step_tick = tick_q & run;

endmodule

// File: tb/tb_turn_input_conditioner.sv
module tb_turn_input_conditioner;

  localparam int D = 4;
  localparam int S = 5;
`ifdef TURN_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic left_raw, right_raw;
  logic left, right, conflict, hazard, step_tick;

  int tests = 0;
  int fails = 0;

  turn_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .STEP_DIV        (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .left_raw  (left_raw),
    .right_raw (right_raw),
    .left      (left),
    .right     (right),
    .conflict  (conflict),
    .hazard    (hazard),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a raw level travels through a 2-edge delay, then a
  // channel's accepted level flips once the delayed input has disagreed with
  // it for D consecutive edges. Requests are registered from the accepted
  // levels; ticks fall on every S-th edge of an uninterrupted active run.
  // ---------------------------------------------------------------------------
  bit [1:0] m_s1, m_s2, m_st;
  int       m_run [2];
  bit       m_l, m_r, m_c, m_h, m_tk;
  int       m_ph;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_st = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_l = 0; m_r = 0; m_c = 0; m_h = 0; m_tk = 0;
    m_ph = 0;
  endtask

  task automatic model_edge(input bit l, input bit r);
    bit run_old, nl, nr, nb, treg;
    run_old = m_l | m_r | m_h;
    nl = m_st[0] & ~m_st[1];
    nr = m_st[1] & ~m_st[0];
    nb = m_st[0] & m_st[1];
    if (run_old) begin
      m_ph++;
      treg = (m_ph % S == 0);
    end else begin
      m_ph = 0;
      treg = 1'b0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (m_s2[ch] != m_st[ch]) m_run[ch]++;
      else m_run[ch] = 0;
      if (m_run[ch] == D) begin
        m_st[ch]  = m_s2[ch];
        m_run[ch] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {r, l};
    m_l  = nl;
    m_r  = nr;
    m_c  = nb & ~HAZ;
    m_h  = nb & HAZ;
    m_tk = treg & (nl | nr | m_h);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive raw inputs at the falling edge, advance the model
  // with the same values on the rising edge, compare at the next falling edge.
  task automatic cyc(input bit l, input bit r);
    left_raw  = l;
    right_raw = r;
    @(posedge clk);
    if (rst_n) model_edge(l, r);
    else model_reset();
    @(negedge clk);
    check("model", 32'({left, right, conflict, hazard, step_tick}),
          32'({m_l, m_r, m_c, m_h, m_tk}));
  endtask

  typedef struct {
    bit l;
    bit r;
    int n;
    bit el;
    bit er;
    bit eb;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit l, input bit r, input int n,
                      input bit el, input bit er, input bit eb);
    vec_t v;
    v.l = l; v.r = r; v.n = n; v.el = el; v.er = er; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int k;
    bit rl, rr;
    int seg;

    // Table: hold raw inputs for n cycles, then expect {left,right,both}.
    addv(0, 0, 7, 0, 0, 0);   // leave the post-reset both-high state
    addv(0, 0, 3, 0, 0, 0);
    addv(1, 0, 6, 0, 0, 0);   // clean press, one edge short
    addv(1, 0, 1, 1, 0, 0);   // edge 7: left
    addv(1, 1, 6, 1, 0, 0);
    addv(1, 1, 1, 0, 0, 1);   // both stable -> conflict / hazard
    addv(0, 1, 6, 0, 0, 1);
    addv(0, 1, 1, 0, 1, 0);   // leaving conflict returns right
    addv(0, 0, 7, 0, 0, 0);
    addv(1, 0, 3, 0, 0, 0);   // bounce: 3 high
    addv(0, 0, 1, 0, 0, 0);   //         1 low
    addv(1, 0, 3, 0, 0, 0);   //         3 high
    addv(0, 0, 8, 0, 0, 0);   //         low
    addv(1, 0, 6, 0, 0, 0);   // final press
    addv(1, 0, 1, 1, 0, 0);
    addv(0, 0, 7, 0, 0, 0);

    // ---- reset with both raw inputs high ----
    rst_n = 1'b0; left_raw = 1'b1; right_raw = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 32'({left, right, conflict, hazard, step_tick}), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1);
      check("rst_quiet", 32'({left, right, conflict, hazard}), 32'd0);
    end
    cyc(1, 1);
    check("rst_both_e7", 32'({left, right, conflict, hazard}), 32'({2'b00, ~HAZ, HAZ}));

    // ---- table-driven vectors ----
    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].l, tbl[i].r);
      check($sformatf("tbl%0d", i), 32'({left, right, conflict, hazard}),
            32'({tbl[i].el, tbl[i].er, tbl[i].eb & ~HAZ, tbl[i].eb & HAZ}));
    end

    // ---- step tick cadence ----
    k = 0;
    do begin cyc(1, 0); k++; end while (left !== 1'b1 && k < 12);
    check("press_lat", 32'(k), 32'd7);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0);
      check($sformatf("tick_c%0d", i), 32'(step_tick), 32'(i % 5 == 0));
    end
    k = 0;
    do begin cyc(0, 0); k++; end while (left !== 1'b0 && k < 12);
    check("release_lat", 32'(k), 32'd7);
    check("tick_idle", 32'(step_tick), 32'd0);
    repeat (6) cyc(0, 0);
    k = 0;
    do begin cyc(1, 0); k++; end while (left !== 1'b1 && k < 12);
    check("repress_lat", 32'(k), 32'd7);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0);
      check($sformatf("retick_c%0d", i), 32'(step_tick), 32'(i == 5));
    end

    // ---- async reset mid-debounce and mid-prescale ----
    repeat (2) cyc(1, 0);
    repeat (4) cyc(1, 1);           // right debounce now part-way through
    check("pre_rst_left", 32'(left), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", 32'({left, right, conflict, hazard, step_tick}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin cyc(1, 1); k++; end while (conflict !== 1'b1 && hazard !== 1'b1 && k < 12);
    check("post_rst_lat", 32'(k), 32'd7);

    // ---- randomized segments against the model ----
    for (int i = 0; i < 60; i++) begin
      rl  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      seg = $urandom_range(1, 12);
      repeat (seg) cyc(rl, rr);
    end
    repeat (12) cyc(0, 0);
    check("final_idle", 32'({left, right, conflict, hazard, step_tick}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
